carrier_nco: RTL

CARRIER_NCO -- requirements
Module: carrier_nco

---
 rtl/gps_pkg.sv | 15 +
 rtl/carrier_lut.sv | 19 +
 rtl/carrier_nco.sv | 84 ++++++++
 3 files changed

// File: rtl/gps_pkg.sv
// Shared widths and carrier replica tables for the GPS tracking blocks.
// Table bit n holds the value for octant n.
package gps_pkg;

  localparam int unsigned NCO_W  = 30;
  localparam int unsigned CYC_W  = 20;
  localparam int unsigned FRAC_W = 10;

  // sign=1 means positive; mag=1 means amplitude 2, mag=0 means amplitude 1
  localparam logic [7:0] I_SIGN_LUT = 8'b1100_0011;
  localparam logic [7:0] I_MAG_LUT  = 8'b1001_1001;
  localparam logic [7:0] Q_SIGN_LUT = 8'b0000_1111;
  localparam logic [7:0] Q_MAG_LUT  = 8'b0110_0110;

endpackage

// File: rtl/carrier_lut.sv
// Octant to I/Q sign/magnitude lookup for the carrier replica.
module carrier_lut
  import gps_pkg::*;
(
  input  logic [2:0] octant,
  output logic       i_sign,
  output logic       i_mag,
  output logic       q_sign,
  output logic       q_mag
);

  always_comb begin
    i_sign = I_SIGN_LUT[octant];
    i_mag  = I_MAG_LUT[octant];
    q_sign = Q_SIGN_LUT[octant];
    q_mag  = Q_MAG_LUT[octant];
  end

endmodule

// File: rtl/carrier_nco.sv
// Carrier NCO: phase accumulator with tic-aligned frequency updates and
// whole-cycle / fractional-phase measurement latched on each tic.
module carrier_nco
  import gps_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [NCO_W-1:0]  freq_word,
  input  logic              freq_wr,
  input  logic              tic,
  output logic              i_sign,
  output logic              i_mag,
  output logic              q_sign,
  output logic              q_mag,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [FRAC_W-1:0] phase_frac,
  output logic              meas_valid
);

  localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);

  logic [NCO_W-1:0]  acc_q, acc_d;
  logic [NCO_W-1:0]  active_incr_q, active_incr_d;
  logic [NCO_W-1:0]  pending_incr_q, pending_incr_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
  logic [FRAC_W-1:0] phase_frac_q, phase_frac_d;
  logic              meas_valid_q;
  logic [NCO_W:0]    sum;
  logic              wrap;

  always_comb begin
    sum            = {1'b0, acc_q} + {1'b0, active_incr_q};
    wrap           = sample_en & sum[NCO_W];
    acc_d          = sample_en ? sum[NCO_W-1:0] : acc_q;
    pending_incr_d = freq_wr ? freq_word : pending_incr_q;
    active_incr_d  = active_incr_q;
    cyc_cnt_d      = wrap ? cyc_cnt_q + CycOne : cyc_cnt_q;
    cycle_count_d  = cycle_count_q;
    phase_frac_d   = phase_frac_q;
    if (tic) begin
      // A write in the tic cycle bypasses the pending register
      active_incr_d = freq_wr ? freq_word : pending_incr_q;
      cycle_count_d = cyc_cnt_q;
      phase_frac_d  = acc_q[NCO_W-1 -: FRAC_W];
      // The wrap in the tic cycle belongs to the new interval
      cyc_cnt_d     = wrap ? CycOne : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      active_incr_q  <= '0;
      pending_incr_q <= '0;
      cyc_cnt_q      <= '0;
      cycle_count_q  <= '0;
      phase_frac_q   <= '0;
      meas_valid_q   <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      active_incr_q  <= active_incr_d;
      pending_incr_q <= pending_incr_d;
      cyc_cnt_q      <= cyc_cnt_d;
      cycle_count_q  <= cycle_count_d;
      phase_frac_q   <= phase_frac_d;
      meas_valid_q   <= tic;
    end
  end

  assign cycle_count = cycle_count_q;
  assign phase_frac  = phase_frac_q;
  assign meas_valid  = meas_valid_q;

  carrier_lut u_lut (
    .octant (acc_q[NCO_W-1 -: 3]),
    .i_sign (i_sign),
    .i_mag  (i_mag),
    .q_sign (q_sign),
    .q_mag  (q_mag)
  );

endmodule
